// File: rtl/axis_cmd_packer.sv
// rtl/axis_cmd_packer.sv - write-request FIFO feeding a two-beat TVALID-only command stream
// Each buffered request leaves as an address word {core, reg} followed by its data word.
module axis_cmd_packer #(
   parameter int REG_ADDR_WIDTH = 4,
   parameter int ADDR_WIDTH     = 12,
   parameter int FIFO_DEPTH     = 4,
   parameter int GAP_CYCLES     = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ADDR_WIDTH-1:0]       wr_core_addr,
   input  logic [REG_ADDR_WIDTH-1:0]   wr_reg_addr,
   input  logic [31:0]                 wr_data,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   output logic [31:0]                 cmd_out_TDATA,
   output logic                        cmd_out_TVALID,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        busy
);

   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int CNT_W    = PTR_W + 1;
   localparam int AW_TOTAL = ADDR_WIDTH + REG_ADDR_WIDTH;
   localparam bit NO_GAP   = (GAP_CYCLES == 0);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [7:0]       GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_GAP} state_t;

   state_t           state_q, state_d;
   logic [31:0]      addr_mem_q [FIFO_DEPTH];
   logic [31:0]      data_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [31:0]      hold_data_q, hold_data_d;
   logic [31:0]      tdata_q, tdata_d;
   logic             tvalid_q, tvalid_d;
   logic [7:0]       gap_cnt_q, gap_cnt_d;
   logic             push, pop, fifo_empty, fifo_full;
   logic [31:0]      addr_word;

   assign fifo_empty     = (count_q == '0);
   assign fifo_full      = (count_q == FULL_CNT);
   assign wr_ready       = !fifo_full;
   assign push           = wr_valid && !fifo_full;
   assign fifo_count     = count_q;
   assign busy           = !fifo_empty || (state_q != S_IDLE);
   assign cmd_out_TDATA  = tdata_q;
   assign cmd_out_TVALID = tvalid_q;

   // The address word is packed at push time so the pop path is a plain read.
   always_comb begin
      addr_word = '0;
      addr_word[AW_TOTAL-1:0] = {wr_core_addr, wr_reg_addr};
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem_q[wr_ptr_q] <= addr_word;
         data_mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         hold_data_q <= '0;
         tdata_q     <= '0;
         tvalid_q    <= 1'b0;
         gap_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         hold_data_q <= hold_data_d;
         tdata_q     <= tdata_d;
         tvalid_q    <= tvalid_d;
         gap_cnt_q   <= gap_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (!fifo_empty) state_d = S_ADDR;
         S_ADDR: state_d = S_DATA;
         S_DATA: begin
            if (!NO_GAP)         state_d = S_GAP;
            else if (!fifo_empty) state_d = S_ADDR;
            else                 state_d = S_IDLE;
         end
         S_GAP:  if (gap_cnt_q == 8'd0) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // A pop loads the address beat and parks the data word for the following cycle.
   always_comb begin
      pop         = 1'b0;
      tdata_d     = '0;
      tvalid_d    = 1'b0;
      hold_data_d = hold_data_q;
      gap_cnt_d   = gap_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop         = 1'b1;
               tdata_d     = addr_mem_q[rd_ptr_q];
               tvalid_d    = 1'b1;
               hold_data_d = data_mem_q[rd_ptr_q];
            end
         end
         S_ADDR: begin
            tdata_d  = hold_data_q;
            tvalid_d = 1'b1;
         end
         S_DATA: begin
            if (!NO_GAP) begin
               gap_cnt_d = GAP_LOAD;
            end else if (!fifo_empty) begin
               pop         = 1'b1;
               tdata_d     = addr_mem_q[rd_ptr_q];
               tvalid_d    = 1'b1;
               hold_data_d = data_mem_q[rd_ptr_q];
            end
         end
         S_GAP: begin
            if (gap_cnt_q != 8'd0) gap_cnt_d = gap_cnt_q - 8'd1;
         end
         default: begin
            tvalid_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_axis_cmd_packer.sv
// tb/tb_axis_cmd_packer.sv - randomized bench for axis_cmd_packer, gap-free and GAP_CYCLES=2 instances
module tb_axis_cmd_packer;

   localparam int RAW   = 4;
   localparam int AW    = 12;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic [11:0] core_a, core_b;
   logic [3:0]  reg_a, reg_b;
   logic [31:0] data_a, data_b;
   logic        valid_a, valid_b;
   logic        ready_a, ready_b;
   logic [31:0] tdata_a, tdata_b;
   logic        tvalid_a, tvalid_b;
   logic [2:0]  cnt_a, cnt_b;
   logic        busy_a, busy_b;

   axis_cmd_packer #(.REG_ADDR_WIDTH(RAW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(0)) dut_a (
      .clk(clk), .rst(rst), .wr_core_addr(core_a), .wr_reg_addr(reg_a), .wr_data(data_a),
      .wr_valid(valid_a), .wr_ready(ready_a), .cmd_out_TDATA(tdata_a), .cmd_out_TVALID(tvalid_a),
      .fifo_count(cnt_a), .busy(busy_a));

   axis_cmd_packer #(.REG_ADDR_WIDTH(RAW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(2)) dut_b (
      .clk(clk), .rst(rst), .wr_core_addr(core_b), .wr_reg_addr(reg_b), .wr_data(data_b),
      .wr_valid(valid_b), .wr_ready(ready_b), .cmd_out_TDATA(tdata_b), .cmd_out_TVALID(tvalid_b),
      .fifo_count(cnt_b), .busy(busy_b));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int          obs_a_cyc[$];
   logic [31:0] obs_a_dat[$];
   int          obs_b_cyc[$];
   logic [31:0] obs_b_dat[$];
   logic [31:0] exp_a[$];
   logic [31:0] exp_b[$];

   // Beat log: edge index that produced each valid beat, sampled 1 time unit after the edge.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (tvalid_a === 1'b1) begin
         obs_a_cyc.push_back(cyc);
         obs_a_dat.push_back(tdata_a);
      end
      if (tvalid_b === 1'b1) begin
         obs_b_cyc.push_back(cyc);
         obs_b_dat.push_back(tdata_b);
      end
   end

   function automatic logic [31:0] addr_of(input int c, input int r);
      return 32'(c * (1 << RAW) + r);
   endfunction

   task automatic drive_a(input int c, input int r, input logic [31:0] d, input logic v);
      core_a = 12'(c); reg_a = 4'(r); data_a = d; valid_a = v;
   endtask

   task automatic drive_b(input int c, input int r, input logic [31:0] d, input logic v);
      core_b = 12'(c); reg_b = 4'(r); data_b = d; valid_b = v;
   endtask

   task automatic test_reset;
      drive_a(0, 0, 32'h0, 1'b0);
      drive_b(0, 0, 32'h0, 1'b0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (tvalid_a !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b want 0", tvalid_a); end
      total++; if (tdata_a !== 32'h0) begin bad++; $display("FAIL reset_tdata: got %h want 0", tdata_a); end
      total++; if (cnt_a !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", cnt_a); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
      total++; if (tvalid_b !== 1'b0) begin bad++; $display("FAIL reset_tvalid_b: got %b want 0", tvalid_b); end
      rst = 1'b1;
      @(negedge clk);
      total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_a); end
      total++; if (ready_b !== 1'b1) begin bad++; $display("FAIL reset_ready_b: got %b want 1", ready_b); end
      total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
   endtask

   task automatic test_single;
      int n;
      obs_a_cyc.delete(); obs_a_dat.delete();
      n = cyc + 1;
      drive_a(12'h003, 4'h5, 32'hDEADBEEF, 1'b1);
      @(negedge clk);
      drive_a(0, 0, 32'h0, 1'b0);
      repeat (5) @(negedge clk);
      total++; if (obs_a_dat.size() != 2) begin bad++; $display("FAIL single_beats: got %0d want 2", obs_a_dat.size()); end
      if (obs_a_dat.size() >= 2) begin
         total++; if (obs_a_dat[0] !== 32'h00000035) begin bad++; $display("FAIL single_addr: got %h want 00000035", obs_a_dat[0]); end
         total++; if (obs_a_cyc[0] != n + 1) begin bad++; $display("FAIL single_addr_lat: got edge %0d want %0d", obs_a_cyc[0], n + 1); end
         total++; if (obs_a_dat[1] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data: got %h want deadbeef", obs_a_dat[1]); end
         total++; if (obs_a_cyc[1] != n + 2) begin bad++; $display("FAIL single_data_lat: got edge %0d want %0d", obs_a_cyc[1], n + 2); end
      end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL single_idle_busy: got %b want 0", busy_a); end
   endtask

   task automatic test_addr_fields;
      int c, r;
      logic [31:0] d;
      obs_a_cyc.delete(); obs_a_dat.delete(); exp_a.delete();
      for (int i = 0; i < 8; i++) begin
         c = (i == 0) ? 'hABC : (i == 1) ? 'hFFF : int'($urandom_range(0, 4095));
         r = (i == 0) ? 'hF : (i == 1) ? 0 : int'($urandom_range(0, 15));
         d = $urandom;
         total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL fields_ready: got %b want 1", ready_a); end
         drive_a(c, r, d, 1'b1);
         exp_a.push_back(addr_of(c, r));
         exp_a.push_back(d);
         @(negedge clk);
         drive_a(0, 0, 32'h0, 1'b0);
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      repeat (6) @(negedge clk);
      total++; if (obs_a_dat.size() != exp_a.size()) begin bad++; $display("FAIL fields_beats: got %0d want %0d", obs_a_dat.size(), exp_a.size()); end
      for (int i = 0; i < exp_a.size() && i < obs_a_dat.size(); i++) begin
         total++; if (obs_a_dat[i] !== exp_a[i]) begin bad++; $display("FAIL fields_beat%0d: got %h want %h", i, obs_a_dat[i], exp_a[i]); end
      end
   endtask

   task automatic test_back_to_back;
      int n;
      logic [31:0] d;
      obs_a_cyc.delete(); obs_a_dat.delete(); exp_a.delete();
      n = cyc + 1;
      for (int i = 0; i < 4; i++) begin
         d = $urandom;
         drive_a(i + 16, i, d, 1'b1);
         exp_a.push_back(addr_of(i + 16, i));
         exp_a.push_back(d);
         @(negedge clk);
      end
      drive_a(0, 0, 32'h0, 1'b0);
      repeat (8) @(negedge clk);
      total++; if (obs_a_dat.size() != 8) begin bad++; $display("FAIL b2b_beats: got %0d want 8", obs_a_dat.size()); end
      for (int i = 0; i < 8 && i < obs_a_dat.size(); i++) begin
         total++; if (obs_a_dat[i] !== exp_a[i]) begin bad++; $display("FAIL b2b_beat%0d: got %h want %h", i, obs_a_dat[i], exp_a[i]); end
         total++; if (obs_a_cyc[i] != n + 1 + i) begin bad++; $display("FAIL b2b_edge%0d: got %0d want %0d", i, obs_a_cyc[i], n + 1 + i); end
      end
   endtask

   task automatic test_full;
      int c[8], r[8];
      logic [31:0] d[8];
      int idx, mcnt, seen;
      bit acc, saw_full;
      obs_a_cyc.delete(); obs_a_dat.delete(); exp_a.delete();
      for (int i = 0; i < 8; i++) begin
         c[i] = int'($urandom_range(0, 4095)); r[i] = int'($urandom_range(0, 15)); d[i] = $urandom;
      end
      idx = 0; mcnt = 0; seen = 0; saw_full = 0;
      for (int t = 0; t < 80 && !(idx == 8 && seen == 16); t++) begin
         total++; if (ready_a !== (mcnt != DEPTH)) begin bad++; $display("FAIL full_ready: got %b want %b", ready_a, (mcnt != DEPTH)); end
         total++; if (cnt_a !== 3'(mcnt)) begin bad++; $display("FAIL full_count: got %0d want %0d", cnt_a, mcnt); end
         if (mcnt == DEPTH) saw_full = 1;
         acc = (idx < 8) && (mcnt != DEPTH);
         if (idx < 8) drive_a(c[idx], r[idx], d[idx], 1'b1);
         else         drive_a(0, 0, 32'h0, 1'b0);
         @(negedge clk);
         if (acc) begin
            exp_a.push_back(addr_of(c[idx], r[idx]));
            exp_a.push_back(d[idx]);
            idx++; mcnt++;
         end
         // Each address beat marks one entry leaving the FIFO.
         while (seen < obs_a_dat.size()) begin
            if (seen % 2 == 0) mcnt--;
            seen++;
         end
      end
      drive_a(0, 0, 32'h0, 1'b0);
      total++; if (idx != 8) begin bad++; $display("FAIL full_accepted: got %0d want 8", idx); end
      total++; if (seen != 16) begin bad++; $display("FAIL full_beats: got %0d want 16", seen); end
      total++; if (!saw_full) begin bad++; $display("FAIL full_reached: got 0 want 1"); end
      for (int i = 0; i < exp_a.size() && i < obs_a_dat.size(); i++) begin
         total++; if (obs_a_dat[i] !== exp_a[i]) begin bad++; $display("FAIL full_beat%0d: got %h want %h", i, obs_a_dat[i], exp_a[i]); end
      end
   endtask

   task automatic test_gap;
      int n;
      logic [31:0] d;
      obs_b_cyc.delete(); obs_b_dat.delete(); exp_b.delete();
      n = cyc + 1;
      for (int i = 0; i < 4; i++) begin
         d = $urandom;
         drive_b(int'($urandom_range(0, 4095)), i + 3, d, 1'b1);
         exp_b.push_back(addr_of(int'(core_b), i + 3));
         exp_b.push_back(d);
         @(negedge clk);
      end
      drive_b(0, 0, 32'h0, 1'b0);
      repeat (22) @(negedge clk);
      total++; if (obs_b_dat.size() != 8) begin bad++; $display("FAIL gap_beats: got %0d want 8", obs_b_dat.size()); end
      for (int i = 0; i < 8 && i < obs_b_dat.size(); i++) begin
         total++; if (obs_b_dat[i] !== exp_b[i]) begin bad++; $display("FAIL gap_beat%0d: got %h want %h", i, obs_b_dat[i], exp_b[i]); end
         total++; if (obs_b_cyc[i] != n + 1 + 5 * (i / 2) + (i % 2)) begin
            bad++; $display("FAIL gap_edge%0d: got %0d want %0d", i, obs_b_cyc[i], n + 1 + 5 * (i / 2) + (i % 2));
         end
      end
   endtask

   task automatic test_reset_mid;
      int n;
      logic [31:0] d0, d;
      d0 = $urandom;
      for (int i = 0; i < 3; i++) begin
         drive_a(i + 100, i, (i == 0) ? d0 : 32'($urandom), 1'b1);
         @(negedge clk);
      end
      drive_a(0, 0, 32'h0, 1'b0);
      total++; if (tvalid_a !== 1'b1 || tdata_a !== d0) begin bad++; $display("FAIL mid_data_beat: got %b/%h want 1/%h", tvalid_a, tdata_a, d0); end
      rst = 1'b0;
      #1;
      obs_a_cyc.delete(); obs_a_dat.delete();
      total++; if (tvalid_a !== 1'b0) begin bad++; $display("FAIL mid_tvalid: got %b want 0", tvalid_a); end
      total++; if (tdata_a !== 32'h0) begin bad++; $display("FAIL mid_tdata: got %h want 0", tdata_a); end
      total++; if (cnt_a !== 3'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", cnt_a); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy_a); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (obs_a_dat.size() != 0) begin bad++; $display("FAIL mid_lost_beats: got %0d want 0", obs_a_dat.size()); end
      n = cyc + 1;
      d = $urandom;
      drive_a(12'h7A5, 4'h9, d, 1'b1);
      @(negedge clk);
      drive_a(0, 0, 32'h0, 1'b0);
      repeat (5) @(negedge clk);
      total++; if (obs_a_dat.size() != 2) begin bad++; $display("FAIL mid_after_beats: got %0d want 2", obs_a_dat.size()); end
      if (obs_a_dat.size() >= 2) begin
         total++; if (obs_a_dat[0] !== 32'h00007A59 || obs_a_cyc[0] != n + 1) begin
            bad++; $display("FAIL mid_after_addr: got %h@%0d want 00007a59@%0d", obs_a_dat[0], obs_a_cyc[0], n + 1);
         end
         total++; if (obs_a_dat[1] !== d || obs_a_cyc[1] != n + 2) begin
            bad++; $display("FAIL mid_after_data: got %h@%0d want %h@%0d", obs_a_dat[1], obs_a_cyc[1], d, n + 2);
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      drive_a(0, 0, 32'h0, 1'b0);
      drive_b(0, 0, 32'h0, 1'b0);
      @(negedge clk);
      test_reset();
      test_single();
      test_addr_fields();
      test_back_to_back();
      test_full();
      test_gap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
